// File: rtl/fw_wishbone_sram_ctrl_pkg.sv
// Shared types and width helper for the multi-port Wishbone SRAM controller.
package fw_wishbone_sram_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        WAIT,
        AMO_WB,
        ACK
    } state_t;

    // Minimum-one-bit width able to index n distinct values.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fw_wishbone_sram_amo_alu.sv
// Combinational AMO write-back value from (memory value, operand, opcode).
`include "wishbone_amo_defines.svh"

module fw_wishbone_sram_amo_alu #(
    parameter int DAT_WIDTH = 32
) (
    input  logic [DAT_WIDTH-1:0] rdata,
    input  logic [DAT_WIDTH-1:0] operand,
    input  logic [3:0]           opcode,
    output logic [DAT_WIDTH-1:0] result
);

    always_comb begin
        result = rdata;
        case (opcode)
            `WB_AMO_SWAP: result = operand;
            `WB_AMO_ADD:  result = rdata + operand;
            `WB_AMO_AND:  result = rdata & operand;
            `WB_AMO_OR:   result = rdata | operand;
            `WB_AMO_XOR:  result = rdata ^ operand;
            `WB_AMO_MAXS: result = ($signed(rdata) > $signed(operand)) ? rdata : operand;
            `WB_AMO_MINS: result = ($signed(rdata) < $signed(operand)) ? rdata : operand;
            `WB_AMO_MAXU: result = (rdata > operand) ? rdata : operand;
            `WB_AMO_MINU: result = (rdata < operand) ? rdata : operand;
            default:      result = rdata;
        endcase
    end

endmodule

// File: rtl/wishbone_amo_defines.svh
// Wishbone AMO opcode encoding carried on the cycle tag (t_tgc); zero means a plain access.
`ifndef WISHBONE_AMO_DEFINES_SVH
`define WISHBONE_AMO_DEFINES_SVH
`define WB_AMO_NONE 4'h0
`define WB_AMO_SWAP 4'h1
`define WB_AMO_ADD  4'h2
`define WB_AMO_AND  4'h3
`define WB_AMO_OR   4'h4
`define WB_AMO_XOR  4'h5
`define WB_AMO_MAXS 4'h6
`define WB_AMO_MINS 4'h7
`define WB_AMO_MAXU 4'h8
`define WB_AMO_MINU 4'h9
`endif

// File: rtl/fw_wishbone_sram_ctrl_multi.sv
// N-port round-robin Wishbone target to single SRAM port with configurable read latency.
// Define FW_WB_SRAM_CTRL_AMO_EN to compile in atomic read-modify-write support.
module fw_wishbone_sram_ctrl_multi
    import fw_wishbone_sram_ctrl_pkg::*;
#(
    parameter int ADR_WIDTH = 32,
    parameter int DAT_WIDTH = 32,
    parameter int N_PORTS   = 2,
    parameter int RD_LAT    = 1
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [N_PORTS*ADR_WIDTH-1:0]   t_adr,
    input  logic [N_PORTS*DAT_WIDTH-1:0]   t_dat_w,
    output logic [N_PORTS*DAT_WIDTH-1:0]   t_dat_r,
    input  logic [N_PORTS-1:0]             t_cyc,
    input  logic [N_PORTS-1:0]             t_stb,
    input  logic [N_PORTS-1:0]             t_we,
    input  logic [N_PORTS*DAT_WIDTH/8-1:0] t_sel,
    input  logic [N_PORTS*4-1:0]           t_tgc,
    output logic [N_PORTS-1:0]             t_ack,
    output logic [ADR_WIDTH-1:0]           i_addr,
    output logic                           i_read_en,
    input  logic [DAT_WIDTH-1:0]           i_read_data,
    output logic                           i_write_en,
    output logic [DAT_WIDTH/8-1:0]         i_byte_en,
    output logic [DAT_WIDTH-1:0]           i_write_data
);

    localparam int SEL_W = DAT_WIDTH / 8;
    localparam int G_W   = idx_width(N_PORTS);
    localparam int CNT_W = idx_width(RD_LAT + 1);

    state_t               state_reg, state_next;
    logic [G_W-1:0]       grant_reg, grant_next;
    logic [G_W-1:0]       rr_ptr_reg, rr_ptr_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [DAT_WIDTH-1:0] rdata_reg, rdata_next;

    logic [ADR_WIDTH-1:0] adr_arr [N_PORTS];
    logic [DAT_WIDTH-1:0] dat_arr [N_PORTS];
    logic [SEL_W-1:0]     sel_arr [N_PORTS];
    logic [3:0]           tgc_arr [N_PORTS];

    logic                 ack_all;
    logic [N_PORTS-1:0]   req;
    logic                 win_valid;
    logic [G_W-1:0]       win_idx;
    logic [G_W-1:0]       grant_succ;

    logic [ADR_WIDTH-1:0] g_adr;
    logic [DAT_WIDTH-1:0] g_dat_w;
    logic [SEL_W-1:0]     g_sel;
    logic [3:0]           g_tgc;
    logic                 g_cyc;
    logic                 is_amo;
    logic                 is_write;

    genvar gi;
    generate
        for (gi = 0; gi < N_PORTS; gi++) begin : g_port
            assign adr_arr[gi] = t_adr[gi*ADR_WIDTH +: ADR_WIDTH];
            assign dat_arr[gi] = t_dat_w[gi*DAT_WIDTH +: DAT_WIDTH];
            assign sel_arr[gi] = t_sel[gi*SEL_W +: SEL_W];
            assign tgc_arr[gi] = t_tgc[gi*4 +: 4];
            assign t_dat_r[gi*DAT_WIDTH +: DAT_WIDTH] = rdata_reg;
            assign t_ack[gi] = ack_all && (grant_reg == G_W'(gi));
        end
    endgenerate

    assign req        = t_cyc & t_stb;
    assign g_adr      = adr_arr[grant_reg];
    assign g_dat_w    = dat_arr[grant_reg];
    assign g_sel      = sel_arr[grant_reg];
    assign g_tgc      = tgc_arr[grant_reg];
    assign g_cyc      = t_cyc[grant_reg];
    assign grant_succ = (grant_reg == G_W'(N_PORTS - 1)) ? '0 : grant_reg + 1'b1;

`ifdef FW_WB_SRAM_CTRL_AMO_EN
    logic [DAT_WIDTH-1:0] alu_result;

    assign is_amo = (g_tgc != 4'd0);

    fw_wishbone_sram_amo_alu #(
        .DAT_WIDTH (DAT_WIDTH)
    ) u_amo_alu (
        .rdata   (rdata_reg),
        .operand (g_dat_w),
        .opcode  (g_tgc),
        .result  (alu_result)
    );
`else
    logic unused_tgc;

    assign is_amo     = 1'b0;
    assign unused_tgc = ^g_tgc;
`endif

    assign is_write = !is_amo && t_we[grant_reg];

    // Rotating priority: first requester at or after rr_ptr, wrapping modulo N_PORTS.
    always_comb begin
        int cand;
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int i = 0; i < N_PORTS; i++) begin
            cand = (int'(rr_ptr_reg) + i) % N_PORTS;
            if (!win_valid && req[cand]) begin
                win_valid = 1'b1;
                win_idx   = G_W'(cand);
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        grant_next   = grant_reg;
        rr_ptr_next  = rr_ptr_reg;
        cnt_next     = cnt_reg;
        rdata_next   = rdata_reg;
        ack_all      = 1'b0;
        i_addr       = '0;
        i_read_en    = 1'b0;
        i_write_en   = 1'b0;
        i_byte_en    = '0;
        i_write_data = '0;

        case (state_reg)
            IDLE: begin
                if (win_valid) begin
                    grant_next = win_idx;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (!g_cyc) begin
                    state_next  = IDLE;
                    rr_ptr_next = grant_succ;
                end else if (is_write) begin
                    i_addr       = g_adr;
                    i_write_en   = 1'b1;
                    i_byte_en    = g_sel;
                    i_write_data = g_dat_w;
                    state_next   = ACK;
                end else begin
                    i_addr     = g_adr;
                    i_read_en  = 1'b1;
                    i_byte_en  = is_amo ? '1 : g_sel;
                    cnt_next   = CNT_W'(RD_LAT);
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (!g_cyc) begin
                    state_next  = IDLE;
                    rr_ptr_next = grant_succ;
                    cnt_next    = '0;
                end else if (cnt_reg <= CNT_W'(1)) begin
                    rdata_next = i_read_data;
                    cnt_next   = '0;
                    state_next = is_amo ? AMO_WB : ACK;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
`ifdef FW_WB_SRAM_CTRL_AMO_EN
            AMO_WB: begin
                i_addr       = g_adr;
                i_write_en   = 1'b1;
                i_byte_en    = '1;
                i_write_data = alu_result;
                state_next   = ACK;
            end
`endif
            ACK: begin
                ack_all     = 1'b1;
                rr_ptr_next = grant_succ;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            grant_reg  <= '0;
            rr_ptr_reg <= '0;
            cnt_reg    <= '0;
            rdata_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            rr_ptr_reg <= rr_ptr_next;
            cnt_reg    <= cnt_next;
            rdata_reg  <= rdata_next;
        end
    end

endmodule

// File: tb/tb_fw_wishbone_sram_ctrl_multi.sv
// Scoreboard bench for fw_wishbone_sram_ctrl_multi with a behavioural byte-enable SRAM.
module tb_fw_wishbone_sram_ctrl_multi;

    localparam int N      = 2;
    localparam int RD_LAT = 2;

    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_MAXS = 4'h6;
    localparam logic [3:0] OP_MAXU = 4'h8;
    localparam logic [3:0] OP_MINU = 4'h9;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [N*32-1:0] t_adr, t_dat_w, t_dat_r;
    logic [N-1:0]  t_cyc, t_stb, t_we, t_ack;
    logic [N*4-1:0] t_sel, t_tgc;
    logic [31:0]   i_addr, i_read_data, i_write_data;
    logic          i_read_en, i_write_en;
    logic [3:0]    i_byte_en;

    logic          cyc_a [N];
    logic          stb_a [N];
    logic          we_a  [N];
    logic [31:0]   adr_a [N];
    logic [31:0]   dat_a [N];
    logic [3:0]    sel_a [N];
    logic [3:0]    tgc_a [N];

    logic [31:0]   mem  [256];
    logic [31:0]   pipe [RD_LAT];

    typedef struct {
        int          port;
        logic [31:0] data;
        bit          chk;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   ack_cnt = 0;
    int   cyc = 0;

    fw_wishbone_sram_ctrl_multi #(
        .ADR_WIDTH (32),
        .DAT_WIDTH (32),
        .N_PORTS   (N),
        .RD_LAT    (RD_LAT)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .t_adr        (t_adr),
        .t_dat_w      (t_dat_w),
        .t_dat_r      (t_dat_r),
        .t_cyc        (t_cyc),
        .t_stb        (t_stb),
        .t_we         (t_we),
        .t_sel        (t_sel),
        .t_tgc        (t_tgc),
        .t_ack        (t_ack),
        .i_addr       (i_addr),
        .i_read_en    (i_read_en),
        .i_read_data  (i_read_data),
        .i_write_en   (i_write_en),
        .i_byte_en    (i_byte_en),
        .i_write_data (i_write_data)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always_comb begin
        for (int p = 0; p < N; p++) begin
            t_cyc[p]            = cyc_a[p];
            t_stb[p]            = stb_a[p];
            t_we[p]             = we_a[p];
            t_adr[p*32 +: 32]   = adr_a[p];
            t_dat_w[p*32 +: 32] = dat_a[p];
            t_sel[p*4 +: 4]     = sel_a[p];
            t_tgc[p*4 +: 4]     = tgc_a[p];
        end
    end

    // SRAM model: byte-masked write, read data valid RD_LAT cycles after read_en.
    assign i_read_data = pipe[RD_LAT-1];
    always @(posedge clock) begin
        if (i_write_en)
            for (int b = 0; b < 4; b++)
                if (i_byte_en[b]) mem[i_addr[7:0]][b*8 +: 8] <= i_write_data[b*8 +: 8];
        if (i_read_en) pipe[0] <= mem[i_addr[7:0]];
        for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
    end

    // Monitor: pops the scoreboard on every ack and checks port, data and cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (i_read_en || i_write_en) begin
                total++;
                if (i_read_en && i_write_en) begin
                    bad++;
                    $display("FAIL strobe_excl: read_en=%0b write_en=%0b, required not both", i_read_en, i_write_en);
                end
            end
            for (int p = 0; p < N; p++) begin
                if (t_ack[p]) begin
                    ack_cnt++;
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_ack: port %0d acked at cycle %0d, required no ack", p, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.port != p) begin
                            bad++;
                            $display("FAIL ack_port: got port %0d, required port %0d", p, e.port);
                        end else if (e.chk && t_dat_r[p*32 +: 32] !== e.data) begin
                            bad++;
                            $display("FAIL rdata port %0d: got %08h, required %08h", p, t_dat_r[p*32 +: 32], e.data);
                        end else if (e.due >= 0 && cyc != e.due) begin
                            bad++;
                            $display("FAIL ack_cycle port %0d: got cycle %0d, required %0d", p, cyc, e.due);
                        end else begin
                            $display("ack port=%0d data=%08h cycle=%0d ok", p, t_dat_r[p*32 +: 32], cyc);
                        end
                    end
                end
            end
        end
    end

    task automatic set_req(input int p, input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel, input logic [3:0] tgc);
        cyc_a[p] = 1'b1;
        stb_a[p] = 1'b1;
        we_a[p]  = we;
        adr_a[p] = adr;
        dat_a[p] = dat;
        sel_a[p] = sel;
        tgc_a[p] = tgc;
    endtask

    task automatic drop(input int p);
        cyc_a[p] = 1'b0;
        stb_a[p] = 1'b0;
    endtask

    task automatic wb_txn(input int p, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic [3:0] tgc, input bit push,
                          input logic [31:0] exp_data, input bit chk, input int lat);
        bit acked;
        exp_t e;
        @(negedge clock);
        if (push) begin
            e.port = p;
            e.data = exp_data;
            e.chk  = chk;
            e.due  = (lat < 0) ? -1 : cyc + lat;
            exp_q.push_back(e);
        end
        set_req(p, we, adr, dat, sel, tgc);
        acked = 1'b0;
        for (int k = 0; k < 100 && !acked; k++) begin
            @(negedge clock);
            acked = t_ack[p];
        end
        if (!acked) begin
            total++;
            bad++;
            $display("FAIL timeout port %0d adr %08h: got no ack, required ack", p, adr);
        end
        drop(p);
    endtask

    task automatic wr(input int p, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        wb_txn(p, 1'b1, adr, dat, sel, 4'h0, 1'b1, 32'h0, 1'b0, 2);
    endtask

    task automatic rd(input int p, input logic [31:0] adr, input logic [31:0] exp_data);
        wb_txn(p, 1'b0, adr, 32'h0, 4'hF, 4'h0, 1'b1, exp_data, 1'b1, 2 + RD_LAT);
    endtask

    task automatic amo(input int p, input logic [31:0] adr, input logic [31:0] opnd,
                       input logic [3:0] op, input logic [31:0] old_val);
`ifdef FW_WB_SRAM_CTRL_AMO_EN
        wb_txn(p, 1'b0, adr, opnd, 4'hF, op, 1'b1, old_val, 1'b1, 3 + RD_LAT);
`else
        wb_txn(p, 1'b0, adr, opnd, 4'hF, op, 1'b1, old_val, 1'b1, 2 + RD_LAT);
`endif
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %08h, required %08h", name, got, want);
        end else begin
            $display("check %s = %08h ok", name, got);
        end
    endtask

    initial begin
        exp_t e;
        int a0;
        int rst_off;
        for (int p = 0; p < N; p++) begin
            cyc_a[p] = 0; stb_a[p] = 0; we_a[p] = 0;
            adr_a[p] = 0; dat_a[p] = 0; sel_a[p] = 0; tgc_a[p] = 0;
        end
        repeat (3) @(negedge clock);
        check("reset_strobes", {31'h0, i_read_en | i_write_en}, 32'h0);
        check("reset_ack_be", {28'h0, t_ack | 2'b00, 2'b00} | {28'h0, i_byte_en}, 32'h0);
        check("reset_addr", i_addr, 32'h0);
        check("reset_wdata", i_write_data, 32'h0);
        check("reset_dat_r", t_dat_r[31:0] | t_dat_r[63:32], 32'h0);
        reset_n = 1'b1;

        // Basic write/read and byte lanes.
        wr(0, 32'h10, 32'hDEADBEEF, 4'hF);
        rd(0, 32'h10, 32'hDEADBEEF);
        wr(0, 32'h10, 32'h000000AA, 4'h1);
        rd(0, 32'h10, 32'hDEADBEAA);
        wr(1, 32'h20, 32'h12345678, 4'hF);
        wr(1, 32'h20, 32'hAABBCCDD, 4'hA);
        rd(1, 32'h20, 32'hAA34CC78);

        // Round-robin: rr_ptr is 0 after the port-1 write, so port 0 wins first.
        wr(0, 32'h30, 32'h11111111, 4'hF);
        wr(1, 32'h31, 32'h22222222, 4'hF);
        for (int i = 0; i < 3; i++) begin
            e.port = 0; e.data = 32'h11111111; e.chk = 1'b1; e.due = -1; exp_q.push_back(e);
            e.port = 1; e.data = 32'h22222222; exp_q.push_back(e);
        end
        fork
            for (int i = 0; i < 3; i++) wb_txn(0, 1'b0, 32'h30, 32'h0, 4'hF, 4'h0, 1'b0, 32'h0, 1'b0, -1);
            for (int i = 0; i < 3; i++) wb_txn(1, 1'b0, 32'h31, 32'h0, 4'hF, 4'h0, 1'b0, 32'h0, 1'b0, -1);
        join

        // AMOs (plain reads without the AMO build).
        wr(0, 32'h40, 32'h7FFFFFFF, 4'hF);
        amo(0, 32'h40, 32'h1, OP_ADD, 32'h7FFFFFFF);
        wr(0, 32'h41, 32'hFFFFFFFF, 4'hF);
        amo(0, 32'h41, 32'h5, OP_MAXS, 32'hFFFFFFFF);
        wr(0, 32'h42, 32'hFFFFFFFF, 4'hF);
        amo(1, 32'h42, 32'h5, OP_MAXU, 32'hFFFFFFFF);
        wr(0, 32'h43, 32'hF0F0F0F0, 4'hF);
        amo(1, 32'h43, 32'hFF00FF00, OP_XOR, 32'hF0F0F0F0);
        wr(0, 32'h44, 32'h3, 4'hF);
        amo(0, 32'h44, 32'hFFFFFFFF, OP_MINU, 32'h3);
`ifdef FW_WB_SRAM_CTRL_AMO_EN
        rd(0, 32'h40, 32'h80000000);
        rd(0, 32'h41, 32'h00000005);
        rd(1, 32'h42, 32'hFFFFFFFF);
        rd(1, 32'h43, 32'h0FF00FF0);
        rd(0, 32'h44, 32'h00000003);
        rst_off = 2 + RD_LAT;
`else
        rd(0, 32'h40, 32'h7FFFFFFF);
        rd(0, 32'h41, 32'hFFFFFFFF);
        rd(0, 32'h43, 32'hF0F0F0F0);
        rst_off = 1;
`endif

        // Abort in WAIT: no ack, memory untouched.
        wr(0, 32'h50, 32'h00000055, 4'hF);
        @(negedge clock);
        a0 = ack_cnt;
        set_req(0, 1'b0, 32'h50, 32'h1, 4'hF, OP_ADD);
        repeat (2) @(negedge clock);
        drop(0);
        repeat (8) @(negedge clock);
        check("abort_no_ack", ack_cnt, a0);
        rd(0, 32'h50, 32'h00000055);

        // Reset in the middle of an AMO (or a read in the plain build).
        wr(0, 32'h60, 32'h00000066, 4'hF);
        @(negedge clock);
        set_req(0, 1'b0, 32'h60, 32'h1, 4'hF, OP_ADD);
        repeat (rst_off) @(negedge clock);
        check("strobe_before_reset", {31'h0, i_read_en | i_write_en}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("reset_outputs_zero", {27'h0, i_read_en, i_write_en, t_ack, 1'b0} | {28'h0, i_byte_en}, 32'h0);
        check("reset_addr_zero", i_addr | i_write_data | t_dat_r[31:0], 32'h0);
        drop(0);
        @(negedge clock);
        reset_n = 1'b1;
        // rr_ptr back to 0: port 0 must win a simultaneous request.
        e.port = 0; e.data = 32'h00000066; e.chk = 1'b1; e.due = -1; exp_q.push_back(e);
        e.port = 1; e.data = 32'h00000055; exp_q.push_back(e);
        fork
            wb_txn(0, 1'b0, 32'h60, 32'h0, 4'hF, 4'h0, 1'b0, 32'h0, 1'b0, -1);
            wb_txn(1, 1'b0, 32'h50, 32'h0, 4'hF, 4'h0, 1'b0, 32'h0, 1'b0, -1);
        join

        repeat (4) @(negedge clock);
        check("scoreboard_drained", exp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule
